// File: rtl/fpu_wb_arbiter_if.sv
// Completion inputs from the fadd/fsub/fmul units and the single float
// register-file write port, bundled for the writeback arbiter.
interface fpu_wb_arbiter_if;
   logic [2:0]  in_flag;
   logic [14:0] in_address;
   logic [95:0] in_result;

   logic        wb_flag;
   logic [4:0]  wb_address;
   logic [31:0] wb_data;
   logic [1:0]  wb_src;
   logic [2:0]  almost_full;
   logic [2:0]  overflow;

   modport master (
      output in_flag,
      output in_address,
      output in_result,
      input  wb_flag,
      input  wb_address,
      input  wb_data,
      input  wb_src,
      input  almost_full,
      input  overflow
   );

   modport slave (
      input  in_flag,
      input  in_address,
      input  in_result,
      output wb_flag,
      output wb_address,
      output wb_data,
      output wb_src,
      output almost_full,
      output overflow
   );
endinterface

// File: rtl/fpu_wb_arbiter.sv
// Writeback collector: one FIFO per floating-point unit, drained round-robin
// into the single register-file write port, one write per cycle.
module fpu_wb_arbiter #(
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic            clk,
   input  logic            rst,
   fpu_wb_arbiter_if.slave bus
);
   localparam int NSRC = 3;
   localparam int PW   = $clog2(DEPTH);
   localparam int CW   = PW + 1;

   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_THRESH = CW'(DEPTH - AF_MARGIN);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [PW-1:0] PTR_ONE   = PW'(1);

   logic [4:0]    r_addrMem [NSRC][DEPTH];
   logic [31:0]   r_dataMem [NSRC][DEPTH];
   logic [PW-1:0] r_wptr    [NSRC];
   logic [PW-1:0] r_rptr    [NSRC];
   logic [CW-1:0] r_count   [NSRC];
   logic [2:0]    r_overflow;
   logic [1:0]    r_last;

   logic          r_wbFlag;
   logic [4:0]    r_wbAddress;
   logic [31:0]   r_wbData;
   logic [1:0]    r_wbSrc;

   logic [2:0]    w_nonEmpty;
   logic [2:0]    w_full;
   logic [2:0]    w_almostFull;
   logic [2:0]    w_push;
   logic [2:0]    w_pop;
   logic [2:0]    w_drop;
   logic [1:0]    w_order [NSRC];
   logic          w_grantValid;
   logic [1:0]    w_grantIdx;
   logic [4:0]    w_headAddr;
   logic [31:0]   w_headData;

   always_comb begin
      w_nonEmpty   = '0;
      w_full       = '0;
      w_almostFull = '0;
      for (int i = 0; i < NSRC; i++) begin
         w_nonEmpty[i]   = (r_count[i] != '0);
         w_full[i]       = (r_count[i] == FULL_CNT);
         w_almostFull[i] = (r_count[i] >= AF_THRESH);
      end
   end

   // Search order starts just after the most recent winner.
   always_comb begin
      w_order[0] = 2'd0;
      w_order[1] = 2'd1;
      w_order[2] = 2'd2;
      case (r_last)
         2'd0: begin
            w_order[0] = 2'd1;
            w_order[1] = 2'd2;
            w_order[2] = 2'd0;
         end
         2'd1: begin
            w_order[0] = 2'd2;
            w_order[1] = 2'd0;
            w_order[2] = 2'd1;
         end
         default: begin
            w_order[0] = 2'd0;
            w_order[1] = 2'd1;
            w_order[2] = 2'd2;
         end
      endcase
   end

   always_comb begin
      w_grantValid = 1'b0;
      w_grantIdx   = 2'd0;
      for (int k = 0; k < NSRC; k++) begin
         if (!w_grantValid && w_nonEmpty[w_order[k]]) begin
            w_grantValid = 1'b1;
            w_grantIdx   = w_order[k];
         end
      end
      w_pop      = w_grantValid ? (3'b001 << w_grantIdx) : 3'b000;
      w_headAddr = r_addrMem[w_grantIdx][r_rptr[w_grantIdx]];
      w_headData = r_dataMem[w_grantIdx][r_rptr[w_grantIdx]];
   end

   // A full FIFO still accepts a completion when its head leaves the same cycle.
   always_comb begin
      w_push = '0;
      w_drop = '0;
      for (int i = 0; i < NSRC; i++) begin
         w_push[i] = bus.in_flag[i] && (!w_full[i] || w_pop[i]);
         w_drop[i] = bus.in_flag[i] && w_full[i] && !w_pop[i];
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NSRC; i++) begin
         if (w_push[i]) begin
            r_addrMem[i][r_wptr[i]] <= bus.in_address[5*i +: 5];
            r_dataMem[i][r_wptr[i]] <= bus.in_result[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NSRC; i++) begin
            r_wptr[i]  <= '0;
            r_rptr[i]  <= '0;
            r_count[i] <= '0;
         end
         r_overflow <= '0;
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            if (w_push[i]) begin
               r_wptr[i] <= r_wptr[i] + PTR_ONE;
            end
            if (w_pop[i]) begin
               r_rptr[i] <= r_rptr[i] + PTR_ONE;
            end
            if (w_push[i] && !w_pop[i]) begin
               r_count[i] <= r_count[i] + CNT_ONE;
            end else if (!w_push[i] && w_pop[i]) begin
               r_count[i] <= r_count[i] - CNT_ONE;
            end
            if (w_drop[i]) begin
               r_overflow[i] <= 1'b1;
            end
         end
      end
   end

   // Write-port fields hold their last value on idle cycles; only the flag drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wbFlag    <= 1'b0;
         r_wbAddress <= '0;
         r_wbData    <= '0;
         r_wbSrc     <= '0;
         r_last      <= 2'd2;
      end else if (w_grantValid) begin
         r_wbFlag    <= 1'b1;
         r_wbAddress <= w_headAddr;
         r_wbData    <= w_headData;
         r_wbSrc     <= w_grantIdx;
         r_last      <= w_grantIdx;
      end else begin
         r_wbFlag    <= 1'b0;
      end
   end

   assign bus.wb_flag     = r_wbFlag;
   assign bus.wb_address  = r_wbAddress;
   assign bus.wb_data     = r_wbData;
   assign bus.wb_src      = r_wbSrc;
   assign bus.almost_full = w_almostFull;
   assign bus.overflow    = r_overflow;
endmodule

// File: tb/tb_fpu_wb_arbiter.sv
// Directed vector bench for fpu_wb_arbiter: table of per-cycle stimulus with
// hand-computed writeback, almost-full and overflow expectations.
module tb_fpu_wb_arbiter;
   typedef struct {
      logic       rstPulse;
      logic [2:0] flag;
      logic [4:0] a0;
      logic [4:0] a1;
      logic [4:0] a2;
      logic       ef;
      logic [4:0] ea;
      logic [1:0] es;
      logic [2:0] eaf;
      logic [2:0] eov;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   vecCount  = 0;
   int   missCount = 0;
   vec_t vecs[$];

   fpu_wb_arbiter_if bus();

   fpu_wb_arbiter #(.DEPTH(4), .AF_MARGIN(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Distinct data per (source, address); source 0 address 0 maps to zero.
   function automatic logic [31:0] dataOf(input logic [1:0] s, input logic [4:0] a);
      logic [31:0] x;
      x = {25'd0, s, a};
      return x * 32'h01010101;
   endfunction

   function automatic vec_t mk(input int r, input int flag, input int a0, input int a1,
                               input int a2, input int ef, input int ea, input int es,
                               input int eaf, input int eov);
      vec_t v;
      v.rstPulse = 1'(r);
      v.flag     = 3'(flag);
      v.a0       = 5'(a0);
      v.a1       = 5'(a1);
      v.a2       = 5'(a2);
      v.ef       = 1'(ef);
      v.ea       = 5'(ea);
      v.es       = 2'(es);
      v.eaf      = 3'(eaf);
      v.eov      = 3'(eov);
      return v;
   endfunction

   task automatic driveInputs(input logic [2:0] flag, input logic [4:0] a0,
                              input logic [4:0] a1, input logic [4:0] a2);
      bus.in_flag    = flag;
      bus.in_address = {a2, a1, a0};
      bus.in_result  = {dataOf(2'd2, a2), dataOf(2'd1, a1), dataOf(2'd0, a0)};
   endtask

   task automatic applyStimulus(input vec_t v);
      if (v.rstPulse) begin
         rst = 1'b1;
         #2;
         rst = 1'b0;
      end
      driveInputs(v.flag, v.a0, v.a1, v.a2);
   endtask

   task automatic checkOutput(input string name, input logic ef, input logic [4:0] ea,
                              input logic [31:0] ed, input logic [1:0] es,
                              input logic [2:0] eaf, input logic [2:0] eov);
      vecCount++;
      if (bus.wb_flag !== ef) begin
         missCount++;
         $display("[TB] FAIL %s wb_flag got %0b want %0b", name, bus.wb_flag, ef);
      end
      if (bus.wb_address !== ea) begin
         missCount++;
         $display("[TB] FAIL %s wb_address got %0d want %0d", name, bus.wb_address, ea);
      end
      if (bus.wb_data !== ed) begin
         missCount++;
         $display("[TB] FAIL %s wb_data got %08h want %08h", name, bus.wb_data, ed);
      end
      if (bus.wb_src !== es) begin
         missCount++;
         $display("[TB] FAIL %s wb_src got %0d want %0d", name, bus.wb_src, es);
      end
      if (bus.almost_full !== eaf) begin
         missCount++;
         $display("[TB] FAIL %s almost_full got %03b want %03b", name, bus.almost_full, eaf);
      end
      if (bus.overflow !== eov) begin
         missCount++;
         $display("[TB] FAIL %s overflow got %03b want %03b", name, bus.overflow, eov);
      end
   endtask

   initial begin
      // Three-way collision right after reset: src0, src1, src2 in order.
      vecs.push_back(mk(1, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b111, 1, 2, 3,  0, 0, 0, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 1, 0, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 2, 1, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 3, 2, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  0, 3, 2, 3'b000, 3'b000));
      // Fairness: src0 and src2 push 8 cycles; src2's 8th push hits a full FIFO.
      vecs.push_back(mk(1, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b101, 0, 0, 16, 0, 0, 0, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b101, 1, 0, 17, 1, 0, 0, 3'b100, 3'b000));
      vecs.push_back(mk(0, 3'b101, 2, 0, 18, 1, 16, 2, 3'b101, 3'b000));
      vecs.push_back(mk(0, 3'b101, 3, 0, 19, 1, 1, 0, 3'b101, 3'b000));
      vecs.push_back(mk(0, 3'b101, 4, 0, 20, 1, 17, 2, 3'b101, 3'b000));
      vecs.push_back(mk(0, 3'b101, 5, 0, 21, 1, 2, 0, 3'b101, 3'b000));
      vecs.push_back(mk(0, 3'b101, 6, 0, 22, 1, 18, 2, 3'b101, 3'b000));
      vecs.push_back(mk(0, 3'b101, 7, 0, 23, 1, 3, 0, 3'b101, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 19, 2, 3'b101, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 4, 0, 3'b101, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 20, 2, 3'b101, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 5, 0, 3'b101, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 21, 2, 3'b001, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 6, 0, 3'b000, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 22, 2, 3'b000, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 7, 0, 3'b000, 3'b100));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  0, 7, 0, 3'b000, 3'b100));
      // src1 fills under contention: full push+pop at edge 6, dropped push at edge 7.
      vecs.push_back(mk(1, 3'b000, 0, 0, 0,  0, 0, 0, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b111, 0, 8, 16, 0, 0, 0, 3'b000, 3'b000));
      vecs.push_back(mk(0, 3'b111, 1, 9, 17, 1, 0, 0, 3'b110, 3'b000));
      vecs.push_back(mk(0, 3'b111, 2, 10, 18, 1, 8, 1, 3'b111, 3'b000));
      vecs.push_back(mk(0, 3'b010, 0, 11, 0, 1, 16, 2, 3'b111, 3'b000));
      vecs.push_back(mk(0, 3'b010, 0, 12, 0, 1, 1, 0, 3'b110, 3'b000));
      vecs.push_back(mk(0, 3'b010, 0, 13, 0, 1, 9, 1, 3'b110, 3'b000));
      vecs.push_back(mk(0, 3'b010, 0, 14, 0, 1, 17, 2, 3'b010, 3'b010));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 2, 0, 3'b010, 3'b010));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 10, 1, 3'b010, 3'b010));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 18, 2, 3'b010, 3'b010));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 11, 1, 3'b010, 3'b010));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 12, 1, 3'b000, 3'b010));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  1, 13, 1, 3'b000, 3'b010));
      vecs.push_back(mk(0, 3'b000, 0, 0, 0,  0, 13, 1, 3'b000, 3'b010));

      rst = 1'b1;
      driveInputs(3'b000, 5'd0, 5'd0, 5'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset", 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b000);
      rst = 1'b0;

      // Single fsub completion: one cycle from capture to write.
      bus.in_flag    = 3'b010;
      bus.in_address = 15'(5) << 5;
      bus.in_result  = 96'h3F800000 << 32;
      @(posedge clk);
      #1;
      driveInputs(3'b000, 5'd0, 5'd0, 5'd0);
      checkOutput("single.E0", 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b000);
      @(posedge clk);
      #1;
      checkOutput("single.E1", 1'b1, 5'd5, 32'h3F800000, 2'd1, 3'b000, 3'b000);
      @(posedge clk);
      #1;
      checkOutput("single.E2", 1'b0, 5'd5, 32'h3F800000, 2'd1, 3'b000, 3'b000);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].ef, vecs[i].ea,
                     dataOf(vecs[i].es, vecs[i].ea), vecs[i].es, vecs[i].eaf, vecs[i].eov);
      end

      // Asynchronous reset between edges with all FIFOs partially full.
      rst = 1'b1;
      #2;
      rst = 1'b0;
      driveInputs(3'b111, 5'd4, 5'd5, 5'd6);
      @(posedge clk);
      #1;
      driveInputs(3'b111, 5'd7, 5'd8, 5'd9);
      @(posedge clk);
      #1;
      checkOutput("midrst.grant", 1'b1, 5'd4, dataOf(2'd0, 5'd4), 2'd0, 3'b110, 3'b000);
      driveInputs(3'b000, 5'd0, 5'd0, 5'd0);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("midrst.async", 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b000);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("midrst.quiet%0d", c), 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b000);
      end
      driveInputs(3'b111, 5'd12, 5'd13, 5'd14);
      @(posedge clk);
      #1;
      driveInputs(3'b000, 5'd0, 5'd0, 5'd0);
      checkOutput("midrst.capture", 1'b0, 5'd0, 32'h0, 2'd0, 3'b000, 3'b000);
      @(posedge clk);
      #1;
      checkOutput("midrst.first", 1'b1, 5'd12, dataOf(2'd0, 5'd12), 2'd0, 3'b000, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule
